// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, issues one word fetch at a time to instruction memory,
// and presents each returned instruction with its PC in the IF/ID register.
//
// state  | meaning
// S_REQ  | ready to issue a fetch for pc_q (unless the skid buffer is full or a redirect is pending)
// S_WAIT | one fetch outstanding; its response is delivered to IF/ID or the skid buffer
// S_DROP | one fetch outstanding that a redirect made stale; its response is discarded
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        if_valid_o,
    output logic [31:0] if_pc_o,
    output logic [31:0] if_instr_o,
    output logic [6:0]  if_opcode_o
);

    localparam logic [1:0] S_REQ  = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_DROP = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] out_pc_q, out_pc_d;
    logic        buf_valid_q, buf_valid_d;
    logic [31:0] buf_pc_q, buf_pc_d;
    logic [31:0] buf_instr_q, buf_instr_d;
    logic        if_valid_q, if_valid_d;
    logic [31:0] if_pc_q, if_pc_d;
    logic [31:0] if_instr_q, if_instr_d;
    logic [6:0]  if_opcode_q, if_opcode_d;
    logic        rsp_take;

    // Request is forced low while reset is asserted, not only after the first edge.
    assign imem_req  = rst_n && (state_q == S_REQ) && !buf_valid_q && !redirect_i;
    assign imem_addr = pc_q;
    assign rsp_take  = imem_rvalid && (state_q == S_WAIT);

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        out_pc_d    = out_pc_q;
        buf_valid_d = buf_valid_q;
        buf_pc_d    = buf_pc_q;
        buf_instr_d = buf_instr_q;
        if_valid_d  = if_valid_q;
        if_pc_d     = if_pc_q;
        if_instr_d  = if_instr_q;

        if (redirect_i) begin
            pc_d        = redirect_pc_i & ~32'h3;
            if_valid_d  = 1'b0;
            if_pc_d     = 32'h0;
            if_instr_d  = NOP_INSTR;
            buf_valid_d = 1'b0;
            case (state_q)
                S_WAIT:  state_d = imem_rvalid ? S_REQ : S_DROP;
                S_DROP:  state_d = imem_rvalid ? S_REQ : S_DROP;
                default: state_d = S_REQ;
            endcase
        end else begin
            case (state_q)
                S_REQ: begin
                    if (imem_req && imem_gnt) begin
                        out_pc_d = pc_q;
                        pc_d     = pc_q + 32'd4;
                        state_d  = S_WAIT;
                    end
                end
                S_WAIT:  if (imem_rvalid) state_d = S_REQ;
                S_DROP:  if (imem_rvalid) state_d = S_REQ;
                default: state_d = S_REQ;
            endcase

            // The skid buffer only ever fills while stalled, and no fetch issues while it is full.
            if (!stall_i) begin
                if (buf_valid_q) begin
                    if_valid_d  = 1'b1;
                    if_pc_d     = buf_pc_q;
                    if_instr_d  = buf_instr_q;
                    buf_valid_d = 1'b0;
                end else if (rsp_take) begin
                    if_valid_d = 1'b1;
                    if_pc_d    = out_pc_q;
                    if_instr_d = imem_rdata;
                end else begin
                    if_valid_d = 1'b0;
                    if_pc_d    = 32'h0;
                    if_instr_d = NOP_INSTR;
                end
            end else if (rsp_take) begin
                buf_valid_d = 1'b1;
                buf_pc_d    = out_pc_q;
                buf_instr_d = imem_rdata;
            end
        end

        if_opcode_d = if_instr_d[6:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_REQ;
            pc_q        <= RESET_PC;
            out_pc_q    <= 32'h0;
            buf_valid_q <= 1'b0;
            buf_pc_q    <= 32'h0;
            buf_instr_q <= 32'h0;
            if_valid_q  <= 1'b0;
            if_pc_q     <= 32'h0;
            if_instr_q  <= NOP_INSTR;
            if_opcode_q <= NOP_INSTR[6:0];
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            out_pc_q    <= out_pc_d;
            buf_valid_q <= buf_valid_d;
            buf_pc_q    <= buf_pc_d;
            buf_instr_q <= buf_instr_d;
            if_valid_q  <= if_valid_d;
            if_pc_q     <= if_pc_d;
            if_instr_q  <= if_instr_d;
            if_opcode_q <= if_opcode_d;
        end
    end

    assign if_valid_o  = if_valid_q;
    assign if_pc_o     = if_pc_q;
    assign if_instr_o  = if_instr_q;
    assign if_opcode_o = if_opcode_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed scenarios plus randomized traffic,
// checked every cycle against a transaction-level model of the fetch stage.
module tb_instruction_fetch_unit;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        stall_i = 1'b0;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = 32'h0;
    logic        if_valid_o;
    logic [31:0] if_pc_o;
    logic [31:0] if_instr_o;
    logic [6:0]  if_opcode_o;

    instruction_fetch_unit #(.RESET_PC(32'h0000_0000), .NOP_INSTR(NOP)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .stall_i(stall_i), .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
        .if_valid_o(if_valid_o), .if_pc_o(if_pc_o), .if_instr_o(if_instr_o),
        .if_opcode_o(if_opcode_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    // Model: fetch pointer, outstanding fetch (and whether a redirect made it stale),
    // waiting-while-stalled instructions, and the visible IF/ID contents.
    logic [31:0] m_pc;
    bit          m_out;
    bit          m_stale;
    logic [31:0] m_opc;
    ent_t        m_skid[$];
    bit          m_v;
    logic [31:0] m_ipc;
    logic [31:0] m_instr;

    // Memory side, driven from what the DUT actually requests.
    bit          mem_pend;
    logic [31:0] mem_addr;
    int          mem_cnt;

    bit          directed;
    bit          d_gnt, d_stall, d_redir, d_spur;
    logic [31:0] d_rpc;
    int          d_delay;

    function automatic logic [31:0] mem_word(logic [31:0] a);
        if (a == 32'h0) return 32'h0050_0093;
        if (a == 32'h4) return 32'h00A0_0113;
        return (a * 32'h0100_0193) ^ 32'h5A5A_0000;
    endfunction

    task automatic model_reset();
        m_pc = 32'h0; m_out = 0; m_stale = 0; m_opc = 32'h0;
        m_skid.delete();
        m_v = 0; m_ipc = 32'h0; m_instr = NOP;
        mem_pend = 0; mem_cnt = 0; mem_addr = 32'h0;
    endtask

    task automatic cycle();
        bit gnt, stall, redir, rv, m_req, dut_fire, fire, rsp, good;
        logic [31:0] rpc, rd, req_addr;
        int dly;
        ent_t e;
        @(negedge clk);
        if (directed) begin
            gnt = d_gnt; stall = d_stall; redir = d_redir; rpc = d_rpc; dly = d_delay;
        end else begin
            gnt   = ($urandom_range(99) < 60);
            stall = ($urandom_range(99) < 25);
            redir = ($urandom_range(99) < 5);
            rpc   = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
            dly   = $urandom_range(3);
        end
        rv = 0;
        rd = $urandom;
        if (mem_pend) begin
            if (mem_cnt == 0) begin
                rv = 1;
                rd = mem_word(mem_addr);
            end else begin
                mem_cnt--;
            end
        end else if (directed ? d_spur : ($urandom_range(99) < 10)) begin
            rv = 1;
        end
        imem_gnt = gnt; imem_rvalid = rv; imem_rdata = rd;
        stall_i = stall; redirect_i = redir; redirect_pc_i = rpc;
        #1;
        m_req = !m_out && (m_skid.size() == 0) && !redir;
        chk("imem_req", 32'(imem_req), 32'(m_req));
        if (m_req) chk("imem_addr", imem_addr, m_pc);
        chk("if_valid", 32'(if_valid_o), 32'(m_v));
        if (m_v) chk("if_pc", if_pc_o, m_ipc);
        chk("if_instr", if_instr_o, m_instr);
        chk("if_opcode", 32'(if_opcode_o), 32'(m_instr[6:0]));
        dut_fire = imem_req && gnt;
        req_addr = imem_addr;
        @(posedge clk);
        #1;
        if (dut_fire) begin
            mem_pend = 1; mem_addr = req_addr; mem_cnt = dly;
        end else if (rv && mem_pend) begin
            mem_pend = 0;
        end
        fire = m_req && gnt;
        rsp  = rv && m_out;
        good = rsp && !m_stale;
        if (redir) begin
            m_pc = rpc & ~32'h3;
            m_v = 0; m_ipc = 32'h0; m_instr = NOP;
            m_skid.delete();
            if (m_out && rv) begin
                m_out = 0; m_stale = 0;
            end else if (m_out) begin
                m_stale = 1;
            end
        end else begin
            if (fire) begin
                m_out = 1; m_stale = 0; m_opc = m_pc; m_pc = m_pc + 32'd4;
            end else if (rsp) begin
                m_out = 0; m_stale = 0;
            end
            if (!stall) begin
                if (m_skid.size() > 0) begin
                    e = m_skid.pop_front();
                    m_v = 1; m_ipc = e.pc; m_instr = e.instr;
                end else if (good) begin
                    m_v = 1; m_ipc = m_opc; m_instr = rd;
                end else begin
                    m_v = 0; m_ipc = 32'h0; m_instr = NOP;
                end
            end else if (good) begin
                e.pc = m_opc; e.instr = rd;
                m_skid.push_back(e);
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        imem_gnt = 0; imem_rvalid = 0; stall_i = 0; redirect_i = 0;
        #2 rst_n = 0;
        #1;
        chk("rst_req", 32'(imem_req), 32'h0);
        chk("rst_valid", 32'(if_valid_o), 32'h0);
        chk("rst_pc", if_pc_o, 32'h0);
        chk("rst_instr", if_instr_o, NOP);
        chk("rst_opcode", 32'(if_opcode_o), 32'h13);
        model_reset();
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic set_dir(bit g, bit s, bit r, logic [31:0] p, int dl, bit sp);
        d_gnt = g; d_stall = s; d_redir = r; d_rpc = p; d_delay = dl; d_spur = sp;
    endtask

    initial begin
        model_reset();
        directed = 1;
        set_dir(0, 0, 0, 32'h0, 0, 0);
        repeat (2) @(negedge clk);
        chk("rst_req", 32'(imem_req), 32'h0);
        chk("rst_valid", 32'(if_valid_o), 32'h0);
        chk("rst_instr", if_instr_o, NOP);
        chk("rst_opcode", 32'(if_opcode_o), 32'h13);
        rst_n = 1;

        // Grant held low: request waits at the reset PC.
        repeat (3) begin
            cycle();
            chk("t2_req", 32'(imem_req), 32'h1);
            chk("t2_addr", imem_addr, 32'h0);
            chk("t2_valid", 32'(if_valid_o), 32'h0);
        end

        // Back-to-back fetches with rvalid one cycle after grant.
        set_dir(1, 0, 0, 32'h0, 0, 0);
        cycle(); cycle();
        chk("t1_valid0", 32'(if_valid_o), 32'h1);
        chk("t1_pc0", if_pc_o, 32'h0);
        chk("t1_instr0", if_instr_o, 32'h0050_0093);
        chk("t1_opc0", 32'(if_opcode_o), 32'h13);
        chk("t1_addr1", imem_addr, 32'h4);
        cycle(); cycle();
        chk("t1_pc1", if_pc_o, 32'h4);
        chk("t1_instr1", if_instr_o, 32'h00A0_0113);
        chk("t1_opc1", 32'(if_opcode_o), 32'h13);

        // Stall while the response for 0x8 arrives.
        set_dir(1, 1, 0, 32'h0, 0, 0);
        cycle(); cycle();
        chk("t3_hold_pc", if_pc_o, 32'h4);
        chk("t3_hold_valid", 32'(if_valid_o), 32'h1);
        chk("t3_no_req", 32'(imem_req), 32'h0);
        set_dir(1, 0, 0, 32'h0, 0, 0);
        cycle();
        chk("t3_pc8", if_pc_o, 32'h8);
        chk("t3_req_c", 32'(imem_req), 32'h1);
        chk("t3_addr_c", imem_addr, 32'hC);

        // Redirect while a fetch is outstanding; its late response must be dropped.
        set_dir(1, 0, 0, 32'h0, 1, 0);
        cycle();
        set_dir(0, 0, 1, 32'h100, 0, 0);
        cycle();
        chk("t4_flush_valid", 32'(if_valid_o), 32'h0);
        chk("t4_flush_instr", if_instr_o, NOP);
        set_dir(1, 0, 0, 32'h0, 0, 0);
        cycle();
        chk("t4_valid_after_drop", 32'(if_valid_o), 32'h0);
        chk("t4_addr", imem_addr, 32'h100);
        cycle(); cycle();
        chk("t4_pc100", if_pc_o, 32'h100);
        chk("t4_valid100", 32'(if_valid_o), 32'h1);

        // Redirect and stall together: flush wins, low address bits dropped.
        set_dir(1, 1, 1, 32'h203, 0, 0);
        cycle();
        chk("t5_valid", 32'(if_valid_o), 32'h0);
        chk("t5_instr", if_instr_o, NOP);
        set_dir(0, 0, 0, 32'h0, 0, 0);
        cycle();
        chk("t5_addr", imem_addr, 32'h200);

        // Reset mid-fetch, then a late response that must be ignored.
        set_dir(1, 0, 0, 32'h0, 3, 0);
        cycle();
        do_reset();
        set_dir(0, 0, 0, 32'h0, 0, 1);
        cycle();
        chk("t6_valid", 32'(if_valid_o), 32'h0);
        chk("t6_addr", imem_addr, 32'h0);

        // PC wrap from the top of the address space.
        set_dir(0, 0, 1, 32'hFFFF_FFFF, 0, 0);
        cycle();
        set_dir(1, 0, 0, 32'h0, 0, 0);
        cycle(); cycle();
        chk("t7_pc_top", if_pc_o, 32'hFFFF_FFFC);
        chk("t7_wrap_addr", imem_addr, 32'h0);

        directed = 0;
        for (int blk = 0; blk < 16; blk++) begin
            repeat (250) cycle();
            do_reset();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
